calc_display_seq: RTL and testbench



---
 rtl/calc_display_seq.sv | 208 ++++++++++++++++++++
 tb/tb_calc_display_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/calc_display_seq.sv
// Sequential double-dabble display driver: signed/unsigned capture, BCD conversion, active-low 7-segment output.
// Optional leading-zero blanking is enabled by defining CALC_DISPLAY_LZB_EN.
module calc_display_seq #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      LoadOU,
    input  logic                      signed_i,
    input  logic [DATA_W-1:0]         result_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      ovf_o,
    output logic [7*(DIGITS+1)-1:0]   seg_o
);

    localparam int NIB   = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int BCD_W = 4 * NIB;
    localparam int EXT_N = (NIB > DIGITS) ? NIB : DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    // Segment constants are stored g..a so that bit 0 is segment a.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                  state_r, next_s;
    logic [DATA_W-1:0]       mag_r;
    logic                    neg_r;
    logic [BCD_W-1:0]        bcd_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [7*(DIGITS+1)-1:0] seg_r;
    logic                    ovf_r;
    logic                    done_r;

    logic                    neg_s;
    logic [DATA_W-1:0]       mag_s;
    logic [BCD_W+DATA_W-1:0] shift_s;
    logic [4*EXT_N-1:0]      bcd_ext_s;
    logic                    ovf_s;
    logic [7*(DIGITS+1)-1:0] seg_s;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int n = 0; n < NIB; n++) begin
            if (b[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = b[4*n +: 4] + 4'd3;
            end else begin
                r[4*n +: 4] = b[4*n +: 4];
            end
        end
        return r;
    endfunction

    // Capture-time sign and magnitude; the most-negative value negates to itself, read as unsigned.
    always_comb begin
        neg_s = signed_i & result_i[DATA_W-1];
        if (neg_s) begin
            mag_s = ~result_i + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = result_i;
        end
    end

    // One double-dabble step: adjust every nibble, then shift {bcd, mag} left.
    always_comb begin
        shift_s = {dabble_adj(bcd_r), mag_r} << 1;
    end

    // Overflow detection and digit encoding of the finished accumulator.
    always_comb begin
        bcd_ext_s = '0;
        bcd_ext_s[BCD_W-1:0] = bcd_r;
        ovf_s = 1'b0;
        for (int k = DIGITS; k < EXT_N; k++) begin
            if (bcd_ext_s[4*k +: 4] != 4'd0) begin
                ovf_s = 1'b1;
            end else begin
                ovf_s = ovf_s;
            end
        end
        seg_s = '1;
        seg_s[7*DIGITS +: 7] = neg_r ? SEG_MINUS : SEG_BLANK;
        if (ovf_s) begin
            seg_s[6:0] = SEG_E;
        end else begin
`ifdef CALC_DISPLAY_LZB_EN
            // Scan from the top; digits stay blank until the first nonzero one.
            automatic logic seen = 1'b0;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (bcd_ext_s[4*k +: 4] != 4'd0) begin
                    seen = 1'b1;
                end else begin
                    seen = seen;
                end
                seg_s[7*k +: 7] = seen ? seg_of(bcd_ext_s[4*k +: 4]) : SEG_BLANK;
            end
            seg_s[6:0] = seg_of(bcd_ext_s[3:0]);
`else
            for (int k = 0; k < DIGITS; k++) begin
                seg_s[7*k +: 7] = seg_of(bcd_ext_s[4*k +: 4]);
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (LoadOU) begin
                    next_s = CONV;
                end else begin
                    next_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == LAST_STEP) begin
                    next_s = LATCH;
                end else begin
                    next_s = CONV;
                end
            end
            LATCH:   next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Datapath and display registers; the display only changes in LATCH.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mag_r  <= '0;
            neg_r  <= 1'b0;
            bcd_r  <= '0;
            cnt_r  <= '0;
            seg_r  <= '1;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == LATCH);
            case (state_r)
                IDLE: begin
                    if (LoadOU) begin
                        mag_r <= mag_s;
                        neg_r <= neg_s;
                        bcd_r <= '0;
                        cnt_r <= '0;
                    end
                end
                CONV: begin
                    bcd_r <= shift_s[BCD_W+DATA_W-1:DATA_W];
                    mag_r <= shift_s[DATA_W-1:0];
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                LATCH: begin
                    seg_r <= seg_s;
                    ovf_r <= ovf_s;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_r != IDLE);
    assign done_o = done_r;
    assign ovf_o  = ovf_r;
    assign seg_o  = seg_r;

endmodule

// File: tb/tb_calc_display_seq.sv
// Scoreboard bench for calc_display_seq: a DIGITS=3 and a DIGITS=2 instance, directed vectors.
module tb_calc_display_seq;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        ld = 1'b0, sg = 1'b0;
    logic [7:0]  res = 8'd0;
    logic        busy, done, ovf;
    logic [27:0] seg;
    logic        ld2 = 1'b0, sg2 = 1'b0;
    logic [7:0]  res2 = 8'd0;
    logic        busy2, done2, ovf2;
    logic [20:0] seg2;

    int checks = 0;
    int errors = 0;
    logic [28:0] q1[$];
    logic [21:0] q2[$];

`ifdef CALC_DISPLAY_LZB_EN
    localparam int LZ = 12;
`else
    localparam int LZ = 0;
`endif

    calc_display_seq #(.DATA_W(8), .DIGITS(3)) dut (
        .CLK(CLK), .Reset(Reset), .LoadOU(ld), .signed_i(sg), .result_i(res),
        .busy_o(busy), .done_o(done), .ovf_o(ovf), .seg_o(seg));

    calc_display_seq #(.DATA_W(8), .DIGITS(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .LoadOU(ld2), .signed_i(sg2), .result_i(res2),
        .busy_o(busy2), .done_o(done2), .ovf_o(ovf2), .seg_o(seg2));

    always #5 CLK = ~CLK;

    // Codes 0-9 digits, 10 E, 11 minus, 12 blank; tables written a..g, bit 0 must be a.
    function automatic logic [6:0] enc(input int code);
        logic [6:0] agf;
        logic [6:0] r;
        case (code)
            0: agf = 7'b0000001;  1: agf = 7'b1001111;  2: agf = 7'b0010010;
            3: agf = 7'b0000110;  4: agf = 7'b1001100;  5: agf = 7'b0100100;
            6: agf = 7'b0100000;  7: agf = 7'b0001111;  8: agf = 7'b0000000;
            9: agf = 7'b0000100; 10: agf = 7'b0110000; 11: agf = 7'b1111110;
            default: agf = 7'b1111111;
        endcase
        for (int i = 0; i < 7; i++) r[i] = agf[6-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare display and overflow on every done pulse.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done dut3 seg=%h", seg);
            end else begin
                logic [28:0] e;
                e = q1.pop_front();
                chk("dut3_seg", {36'd0, seg}, {36'd0, e[27:0]});
                chk("dut3_ovf", {63'd0, ovf}, {63'd0, e[28]});
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done dut2 seg=%h", seg2);
            end else begin
                logic [21:0] e;
                e = q2.pop_front();
                chk("dut2_seg", {43'd0, seg2}, {43'd0, e[20:0]});
                chk("dut2_ovf", {63'd0, ovf2}, {63'd0, e[21]});
            end
        end
    end

    task automatic exp3(input int s, input int d2, input int d1, input int d0, input logic o);
        q1.push_back({o, enc(s), enc(d2), enc(d1), enc(d0)});
    endtask

    task automatic load1(input logic s, input logic [7:0] v);
        @(negedge CLK); ld = 1'b1; sg = s; res = v;
        @(negedge CLK); ld = 1'b0;
    endtask

    task automatic load2(input logic s, input logic [7:0] v);
        @(negedge CLK); ld2 = 1'b1; sg2 = s; res2 = v;
        @(negedge CLK); ld2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = (which == 1) ? (done === 1'b1) : (done2 === 1'b1);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout no done within 40 cycles", name);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_seg", {36'd0, seg}, {36'd0, 28'hFFFFFFF});
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        Reset = 1'b1;

        // 1: reset in the middle of a conversion
        load1(1'b0, 8'h7B);
        repeat (3) @(negedge CLK);
        chk("mid_busy_before", {63'd0, busy}, 64'd1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_seg", {36'd0, seg}, {36'd0, 28'hFFFFFFF});
        @(negedge CLK); Reset = 1'b1;
        repeat (15) @(negedge CLK);
        chk("mid_rst_seg_hold", {36'd0, seg}, {36'd0, 28'hFFFFFFF});

        // 2: 127 with cycle-accurate busy/done timing
        exp3(12, 1, 2, 7, 1'b0);
        load1(1'b1, 8'h7F);
        for (int i = 1; i <= 11; i++) begin
            chk($sformatf("t_busy_c%0d", i), {63'd0, busy}, {63'd0, (i <= 9)});
            chk($sformatf("t_done_c%0d", i), {63'd0, done}, {63'd0, (i == 10)});
            @(negedge CLK);
        end

        // 3: most-negative signed, and unsigned max
        exp3(11, 1, 2, 8, 1'b0);
        load1(1'b1, 8'h80);
        wait_done(1, "neg128");
        exp3(12, 2, 5, 5, 1'b0);
        load1(1'b0, 8'hFF);
        wait_done(1, "u255");

        // 4: a load during busy is dropped
        exp3(12, LZ, LZ, 5, 1'b0);
        load1(1'b0, 8'h05);
        repeat (2) @(negedge CLK);
        ld = 1'b1; res = 8'h09;
        @(negedge CLK); ld = 1'b0;
        wait_done(1, "five");
        repeat (15) @(negedge CLK);
        chk("five_hold", {36'd0, seg}, {36'd0, enc(12), enc(LZ), enc(LZ), enc(5)});

        // 5: DIGITS=2 overflow then in-range
        q2.push_back({1'b1, enc(12), enc(12), enc(10)});
        load2(1'b0, 8'd100);
        wait_done(2, "ovf100");
        q2.push_back({1'b0, enc(12), enc(9), enc(9)});
        load2(1'b0, 8'd99);
        wait_done(2, "d99");

        // 6: signed zero, then a load accepted in the done cycle
        exp3(12, LZ, LZ, 0, 1'b0);
        load1(1'b1, 8'h00);
        wait_done(1, "zero");
        exp3(11, 1, 2, 3, 1'b0);
        ld = 1'b1; sg = 1'b1; res = 8'h85;
        @(negedge CLK); ld = 1'b0;
        chk("load_in_done_busy", {63'd0, busy}, 64'd1);
        wait_done(1, "m123");
        repeat (3) @(negedge CLK);

        chk("q1_drained", {32'd0, 32'(q1.size())}, 64'd0);
        chk("q2_drained", {32'd0, 32'(q2.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
